// File: rtl/wb_trap_commit_pkg.sv
// Shared types for the write-back trap sequencer.
// ExceptStruct carries the registered MEM/WB exception pack; TrapPkg holds the
// sequencer state encoding, CSR addresses, mstatus bit positions and privilege
// encodings.

package ExceptStruct;

  // Exception pack as registered in the MEM/WB exception register.
  typedef struct packed {
    logic        except;
    logic [63:0] epc;
    logic [63:0] ecause;
    logic [63:0] etval;
  } ExceptPack;

endpackage

package TrapPkg;

  typedef enum logic [2:0] {
    IDLE,
    W_EPC,
    W_CAUSE,
    W_TVAL,
    W_STATUS,
    REDIRECT
  } trap_state_e;

  // What the latched sequence is doing: trap entry or one of the returns.
  typedef enum logic [1:0] {
    KIND_TRAP,
    KIND_MRET,
    KIND_SRET
  } trap_kind_e;

  // Privilege encodings.
  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  // CSR addresses written by the sequencer.
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_SEPC    = 12'h141;
  localparam logic [11:0] CSR_SCAUSE  = 12'h142;
  localparam logic [11:0] CSR_STVAL   = 12'h143;

  // mstatus bit positions.
  localparam int unsigned MSTATUS_SIE    = 1;
  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_SPIE   = 5;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_SPP    = 8;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  // Pick the M- or S-level copy of a trap CSR according to the trap target.
  function automatic logic [11:0] trap_csr(input logic [1:0]  tgt,
                                           input logic [11:0] m_addr,
                                           input logic [11:0] s_addr);
    return (tgt == PRIV_S) ? s_addr : m_addr;
  endfunction

endpackage

// File: rtl/wb_trap_commit_vec.sv
// TrapVecCalc: turns a trap vector CSR into the trap-entry redirect PC.
// Optional feature macro: TRAP_VECTORED_EN (vectored mode for interrupts).

module TrapVecCalc (
  input  logic [63:0] tvec,
  input  logic        is_irq,
  input  logic [5:0]  cause_code,
  output logic [63:0] pc
);

  logic [63:0] base;

  assign base = {tvec[63:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  // Vectored mode only applies to interrupts; exceptions always use the base.
  always_comb begin
    pc = base;
    if (tvec[1:0] == 2'b01 && is_irq) begin
      pc = base + {56'd0, cause_code, 2'b00};
    end
  end
`else
  logic unused_mode;

  // Direct mode only: the mode field and cause are irrelevant.
  assign unused_mode = ^{tvec[1:0], is_irq, cause_code};
  assign pc          = base;
`endif

endmodule

// File: rtl/wb_trap_commit.sv
// wb_trap_commit: write-back trap sequencer. Owns the privilege level, walks
// the CSR updates of a trap / mret / sret through one CSR write port, then
// emits a single-cycle redirect with a full pipeline flush.
// Optional feature macro: TRAP_VECTORED_EN (forwarded to TrapVecCalc).

module wb_trap_commit
  import ExceptStruct::*;
  import TrapPkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  ExceptPack   except_wb,
  input  logic        valid_wb,
  input  logic        mret_wb,
  input  logic        sret_wb,
  input  logic [63:0] mstatus_i,
  input  logic [63:0] medeleg_i,
  input  logic [63:0] mtvec_i,
  input  logic [63:0] stvec_i,
  input  logic [63:0] mepc_i,
  input  logic [63:0] sepc_i,
  output logic [1:0]  priv,
  output logic        csr_we,
  output logic [11:0] csr_waddr,
  output logic [63:0] csr_wdata,
  output logic        trap_stall,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        flush_all
);

  trap_state_e state_q, state_d;
  logic [1:0]  priv_q, priv_d;
  trap_kind_e  kind_q, kind_d;
  logic [1:0]  tgt_q, tgt_d;
  logic [1:0]  old_priv_q, old_priv_d;
  logic [63:0] epc_q, epc_d;
  logic [63:0] ecause_q, ecause_d;
  logic [63:0] etval_q, etval_d;

  logic [63:0] status_new;
  logic [63:0] trap_pc;

  TrapVecCalc u_vec (
    .tvec       ((tgt_q == PRIV_S) ? stvec_i : mtvec_i),
    .is_irq     (ecause_q[63]),
    .cause_code (ecause_q[5:0]),
    .pc         (trap_pc)
  );

  // Next-state, latch capture and combinational CSR/redirect outputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    state_d        = state_q;
    priv_d         = priv_q;
    kind_d         = kind_q;
    tgt_d          = tgt_q;
    old_priv_d     = old_priv_q;
    epc_d          = epc_q;
    ecause_d       = ecause_q;
    etval_d        = etval_q;
    status_new     = mstatus_i;
    csr_we         = 1'b0;
    csr_waddr      = 12'h000;
    csr_wdata      = 64'd0;
    trap_stall     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;

    case (state_q)
      IDLE: begin
        if (valid_wb && except_wb.except) begin
          epc_d      = except_wb.epc;
          ecause_d   = except_wb.ecause;
          etval_d    = except_wb.etval;
          old_priv_d = priv_q;
          kind_d     = KIND_TRAP;
          tgt_d      = (priv_q != PRIV_M && !except_wb.ecause[63] &&
                        medeleg_i[except_wb.ecause[5:0]]) ? PRIV_S : PRIV_M;
          trap_stall = 1'b1;
          state_d    = W_EPC;
        end else if (valid_wb && mret_wb) begin
          kind_d     = KIND_MRET;
          trap_stall = 1'b1;
          state_d    = W_STATUS;
        end else if (valid_wb && sret_wb) begin
          kind_d     = KIND_SRET;
          trap_stall = 1'b1;
          state_d    = W_STATUS;
        end
      end

      W_EPC: begin
        csr_we     = 1'b1;
        csr_waddr  = trap_csr(tgt_q, CSR_MEPC, CSR_SEPC);
        csr_wdata  = epc_q;
        trap_stall = 1'b1;
        state_d    = W_CAUSE;
      end

      W_CAUSE: begin
        csr_we     = 1'b1;
        csr_waddr  = trap_csr(tgt_q, CSR_MCAUSE, CSR_SCAUSE);
        csr_wdata  = ecause_q;
        trap_stall = 1'b1;
        state_d    = W_TVAL;
      end

      W_TVAL: begin
        csr_we     = 1'b1;
        csr_waddr  = trap_csr(tgt_q, CSR_MTVAL, CSR_STVAL);
        csr_wdata  = etval_q;
        trap_stall = 1'b1;
        state_d    = W_STATUS;
      end

      W_STATUS: begin
        case (kind_q)
          KIND_TRAP: begin
            if (tgt_q == PRIV_S) begin
              status_new[MSTATUS_SPIE] = mstatus_i[MSTATUS_SIE];
              status_new[MSTATUS_SIE]  = 1'b0;
              status_new[MSTATUS_SPP]  = old_priv_q[0];
            end else begin
              status_new[MSTATUS_MPIE] = mstatus_i[MSTATUS_MIE];
              status_new[MSTATUS_MIE]  = 1'b0;
              status_new[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = old_priv_q;
            end
            priv_d = tgt_q;
          end
          KIND_MRET: begin
            status_new[MSTATUS_MIE]  = mstatus_i[MSTATUS_MPIE];
            status_new[MSTATUS_MPIE] = 1'b1;
            status_new[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_U;
            priv_d = mstatus_i[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
          end
          default: begin
            status_new[MSTATUS_SIE]  = mstatus_i[MSTATUS_SPIE];
            status_new[MSTATUS_SPIE] = 1'b1;
            status_new[MSTATUS_SPP]  = 1'b0;
            priv_d = {1'b0, mstatus_i[MSTATUS_SPP]};
          end
        endcase
        csr_we     = 1'b1;
        csr_waddr  = CSR_MSTATUS;
        csr_wdata  = status_new;
        trap_stall = 1'b1;
        state_d    = REDIRECT;
      end

      REDIRECT: begin
        // Anything in WB this cycle is being flushed, so inputs are ignored.
        redirect_valid = 1'b1;
        case (kind_q)
          KIND_TRAP: redirect_pc = trap_pc;
          KIND_MRET: redirect_pc = mepc_i;
          default:   redirect_pc = sepc_i;
        endcase
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Control state: sequencer state and current privilege.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      priv_q  <= PRIV_M;
    end else begin
      state_q <= state_d;
      priv_q  <= priv_d;
    end
  end

  // Latched trap payload; only read after IDLE has captured it.
  always_ff @(posedge clk) begin
    // NOTE: payload registers carry no reset; the state machine never reads them before a capture.
    kind_q     <= kind_d;
    tgt_q      <= tgt_d;
    old_priv_q <= old_priv_d;
    epc_q      <= epc_d;
    ecause_q   <= ecause_d;
    etval_q    <= etval_d;
  end

  assign priv      = priv_q;
  assign flush_all = redirect_valid;

endmodule

// File: tb/tb_wb_trap_commit.sv
// Scoreboard bench for wb_trap_commit: stimulus pushes expected CSR writes and
// redirects (with their cycle numbers); a negedge monitor pops and compares.
// Honors TRAP_VECTORED_EN for the vectored-interrupt expectation.

module tb_wb_trap_commit;
  import ExceptStruct::*;
  import TrapPkg::*;

  logic        clk;
  logic        rst;
  ExceptPack   except_wb;
  logic        valid_wb, mret_wb, sret_wb;
  logic [63:0] mstatus_i, medeleg_i, mtvec_i, stvec_i, mepc_i, sepc_i;
  logic [1:0]  priv;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [63:0] csr_wdata;
  logic        trap_stall, redirect_valid, flush_all;
  logic [63:0] redirect_pc;

  wb_trap_commit dut (
    .clk            (clk),
    .rst            (rst),
    .except_wb      (except_wb),
    .valid_wb       (valid_wb),
    .mret_wb        (mret_wb),
    .sret_wb        (sret_wb),
    .mstatus_i      (mstatus_i),
    .medeleg_i      (medeleg_i),
    .mtvec_i        (mtvec_i),
    .stvec_i        (stvec_i),
    .mepc_i         (mepc_i),
    .sepc_i         (sepc_i),
    .priv           (priv),
    .csr_we         (csr_we),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .trap_stall     (trap_stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_all      (flush_all)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [11:0] addr;
    logic [63:0] data;
  } csr_exp_t;

  typedef struct {
    int          cyc;
    logic [63:0] pc;
    logic [1:0]  priv;
  } red_exp_t;

  csr_exp_t csr_q[$];
  red_exp_t red_q[$];
  bit       mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every presented CSR write / redirect against the queues.
  always @(negedge clk) begin
    csr_exp_t ce;
    red_exp_t re;
    if (mon_en) begin
      if (csr_we === 1'b1) begin
        if (csr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_csr_write: addr 0x%0h data 0x%0h (cycle %0d)", csr_waddr, csr_wdata, cyc);
        end else begin
          ce = csr_q.pop_front();
          check("csr_cycle", 64'(cyc), 64'(ce.cyc));
          check("csr_waddr", {52'd0, csr_waddr}, {52'd0, ce.addr});
          check("csr_wdata", csr_wdata, ce.data);
          check("csr_stall", {63'd0, trap_stall}, 64'd1);
        end
      end else if (csr_q.size() > 0 && csr_q[0].cyc <= cyc) begin
        ce = csr_q.pop_front();
        checks++; errors++;
        $display("FAIL missing_csr_write: got none expected addr 0x%0h (cycle %0d)", ce.addr, cyc);
      end

      if (redirect_valid === 1'b1) begin
        if (red_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_redirect: pc 0x%0h (cycle %0d)", redirect_pc, cyc);
        end else begin
          re = red_q.pop_front();
          check("red_cycle", 64'(cyc), 64'(re.cyc));
          check("red_pc", redirect_pc, re.pc);
          check("red_priv", {62'd0, priv}, {62'd0, re.priv});
          check("red_flush", {63'd0, flush_all}, 64'd1);
          check("red_stall", {63'd0, trap_stall}, 64'd0);
        end
      end else if (red_q.size() > 0 && red_q[0].cyc <= cyc) begin
        re = red_q.pop_front();
        checks++; errors++;
        $display("FAIL missing_redirect: got none expected pc 0x%0h (cycle %0d)", re.pc, cyc);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_wb();
    valid_wb  = 1'b0;
    except_wb = '0;
    mret_wb   = 1'b0;
    sret_wb   = 1'b0;
  endtask

  // Trap entry: four CSR writes at T+1..T+4, redirect at T+5, IDLE at T+6.
  task automatic run_trap(input string name, input logic [63:0] epc, input logic [63:0] cause,
                          input logic [63:0] tval, input logic [1:0] tgt,
                          input logic [63:0] exp_status, input logic [63:0] exp_pc,
                          input logic also_mret, input logic hold);
    int t;
    t = cyc;
    csr_q.push_back('{t + 1, trap_csr(tgt, CSR_MEPC, CSR_SEPC), epc});
    csr_q.push_back('{t + 2, trap_csr(tgt, CSR_MCAUSE, CSR_SCAUSE), cause});
    csr_q.push_back('{t + 3, trap_csr(tgt, CSR_MTVAL, CSR_STVAL), tval});
    csr_q.push_back('{t + 4, CSR_MSTATUS, exp_status});
    red_q.push_back('{t + 5, exp_pc, tgt});
    except_wb.except = 1'b1;
    except_wb.epc    = epc;
    except_wb.ecause = cause;
    except_wb.etval  = tval;
    valid_wb         = 1'b1;
    mret_wb          = also_mret;
    #1;
    check({name, "_accept_stall"}, {63'd0, trap_stall}, 64'd1);
    step();
    if (!hold) clear_wb();
    step(5);
    clear_wb();
    #1;
    check({name, "_idle_stall"}, {63'd0, trap_stall}, 64'd0);
  endtask

  // Return: status write at T+1, redirect at T+2, IDLE at T+3.
  task automatic run_xret(input string name, input logic is_mret, input logic [63:0] exp_status,
                          input logic [63:0] exp_pc, input logic [1:0] exp_priv);
    int t;
    t = cyc;
    csr_q.push_back('{t + 1, CSR_MSTATUS, exp_status});
    red_q.push_back('{t + 2, exp_pc, exp_priv});
    valid_wb = 1'b1;
    mret_wb  = is_mret;
    sret_wb  = !is_mret;
    #1;
    check({name, "_accept_stall"}, {63'd0, trap_stall}, 64'd1);
    step();
    clear_wb();
    step(2);
    check({name, "_idle_stall"}, {63'd0, trap_stall}, 64'd0);
  endtask

  initial begin
    int t;
    clear_wb();
    rst       = 1'b1;
    mstatus_i = 64'd0;
    medeleg_i = 64'd0;
    mtvec_i   = 64'd0;
    stvec_i   = 64'd0;
    mepc_i    = 64'd0;
    sepc_i    = 64'd0;
    step(2);

    // Reset state.
    check("rst_priv", {62'd0, priv}, 64'd3);
    check("rst_csr_we", {63'd0, csr_we}, 64'd0);
    check("rst_csr_waddr", {52'd0, csr_waddr}, 64'd0);
    check("rst_csr_wdata", csr_wdata, 64'd0);
    check("rst_stall", {63'd0, trap_stall}, 64'd0);
    check("rst_redirect", {63'd0, redirect_valid}, 64'd0);
    check("rst_redirect_pc", redirect_pc, 64'd0);
    check("rst_flush", {63'd0, flush_all}, 64'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    step();

    // mret with MPP=U, MPIE=1: MIE=1, MPIE=1, MPP=0 -> 0x88, priv U.
    mstatus_i = 64'h80;
    mepc_i    = 64'h1000;
    run_xret("mret", 1'b1, 64'h88, 64'h1000, PRIV_U);

    // Ecall from U, no delegation; WB exception held through the redirect cycle.
    mstatus_i = 64'h88;
    medeleg_i = 64'd0;
    mtvec_i   = 64'h8000_0100;
    run_trap("ecall_u", 64'h4000_0010, 64'd8, 64'd0, PRIV_M, 64'h80, 64'h8000_0100, 1'b0, 1'b1);

    // sret from M with SPP=1, SPIE=1: SIE=1, SPIE=1, SPP=0 -> 0x22, priv S.
    mstatus_i = 64'h120;
    sepc_i    = 64'h2000;
    run_xret("sret", 1'b0, 64'h22, 64'h2000, PRIV_S);

    // Page fault from S delegated via medeleg[13]: SPIE=1, SIE=0, SPP=1 -> 0x120.
    mstatus_i = 64'h22;
    medeleg_i = 64'h2000;
    stvec_i   = 64'h8000_2000;
    run_trap("pf_s", 64'h5000, 64'd13, 64'hdead_beef, PRIV_S, 64'h120, 64'h8000_2000, 1'b0, 1'b0);

    // Reset during W_CAUSE while in S: EPC and CAUSE writes only, then idle at M.
    medeleg_i = 64'd0;
    t = cyc;
    csr_q.push_back('{t + 1, CSR_MEPC, 64'h7000});
    csr_q.push_back('{t + 2, CSR_MCAUSE, 64'd2});
    except_wb.except = 1'b1;
    except_wb.epc    = 64'h7000;
    except_wb.ecause = 64'd2;
    except_wb.etval  = 64'h55;
    valid_wb         = 1'b1;
    step();
    clear_wb();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid_csr_we", {63'd0, csr_we}, 64'd0);
    check("rstmid_priv", {62'd0, priv}, 64'd3);
    check("rstmid_redirect", {63'd0, redirect_valid}, 64'd0);
    check("rstmid_stall", {63'd0, trap_stall}, 64'd0);
    step(6);

    // Exception and mret together from M: only the trap runs, MPP=3 -> 0x1800.
    mstatus_i = 64'd0;
    medeleg_i = '1;
    mtvec_i   = 64'h8000_0100;
    run_trap("exc_mret", 64'h9000, 64'd2, 64'h44, PRIV_M, 64'h1800, 64'h8000_0100, 1'b1, 1'b0);

    // Interrupt cause 7 with mtvec mode 1.
    mstatus_i = 64'h8;
    mtvec_i   = 64'h8000_0001;
`ifdef TRAP_VECTORED_EN
    run_trap("irq7", 64'h6000, 64'h8000_0000_0000_0007, 64'd0, PRIV_M, 64'h1880,
             64'h8000_001C, 1'b0, 1'b0);
`else
    run_trap("irq7", 64'h6000, 64'h8000_0000_0000_0007, 64'd0, PRIV_M, 64'h1880,
             64'h8000_0000, 1'b0, 1'b0);
`endif

    step(4);
    check("csr_queue_drained", 64'(csr_q.size()), 64'd0);
    check("red_queue_drained", 64'(red_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_trap_commit.md
# wb_trap_commit

Write-back-stage trap sequencer consuming the registered exception pack from the MEM/WB exception register, plus `mret`/`sret` retirement. It owns the current privilege level, which also feeds the instruction examiners, and serialises the CSR updates a trap or return requires through one CSR write port. It then issues a single-cycle PC redirect with a pipeline flush.

## Interface
- No parameters.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `except_wb` in ExceptPack: `except`, `epc`[63:0], `ecause`[63:0], `etval`[63:0].
- `valid_wb` in 1: WB instruction valid.
- `mret_wb`, `sret_wb` in 1: WB instruction is `mret` / `sret`.
- `mstatus_i` in 64: current mstatus.
- `medeleg_i` in 64: exception delegation mask.
- `mtvec_i`, `stvec_i` in 64: trap vectors.
- `mepc_i`, `sepc_i` in 64: return targets.
- `priv` out 2: current privilege (U=0, S=1, M=3).
- `csr_we` out 1: CSR write enable.
- `csr_waddr` out 12: CSR write address.
- `csr_wdata` out 64: CSR write data.
- `trap_stall` out 1: freezes IF..WB while sequencing.
- `redirect_valid` out 1: one-cycle redirect pulse.
- `redirect_pc` out 64: redirect target.
- `flush_all` out 1: flushes all pipeline registers; equals `redirect_valid`.

## Operation
- FSM states: IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, REDIRECT.
- Trap entry, in IDLE, when `valid_wb & except_wb.except`:
  - latch the pack and the old `priv`;
  - target = S if `priv != M`, `ecause[63]==0` and `medeleg_i[ecause[5:0]]`; otherwise target = M;
  - go to W_EPC.
- Trap writes, one per state:
  - W_EPC writes epc to mepc (0x341) or sepc (0x141), by target;
  - W_CAUSE writes ecause to 0x342 or 0x142;
  - W_TVAL writes etval to 0x343 or 0x143;
  - W_STATUS writes mstatus (0x300), using `mstatus_i` sampled in that cycle.
- W_STATUS field updates:
  - M target: MPIE(7)=MIE(3), MIE=0, MPP(12:11)=old priv.
  - S target: SPIE(5)=SIE(1), SIE=0, SPP(8)=old priv[0].
  - `priv` takes the target value at the end of W_STATUS.
- REDIRECT after a trap: `redirect_pc` = target tvec with bits [1:0] cleared; then return to IDLE.
- `mret`, in IDLE, when `valid_wb & mret_wb` and no exception: go straight to W_STATUS.
  - Write MIE=MPIE, MPIE=1, MPP=U.
  - `priv` takes the old MPP value.
  - REDIRECT to `mepc_i`.
- `sret` works the same way: SIE=SPIE, SPIE=1, SPP=0, `priv`={1'b0, SPP}, redirect to `sepc_i`.
- Priority when several arrive in the same cycle: exception > `mret` > `sret`.
- While not in IDLE, WB inputs are ignored; the pipeline is frozen by `trap_stall`.

## Timing
- Reset values:
  - state IDLE, `priv`=3;
  - `csr_we`=0, `csr_waddr`=0, `csr_wdata`=0;
  - `trap_stall`=0, `redirect_valid`=0, `redirect_pc`=0, `flush_all`=0.
- Trap accepted at cycle T:
  - `trap_stall`=1 combinationally in T and through T+4;
  - CSR writes occur in T+1 (EPC), T+2 (CAUSE), T+3 (TVAL) and T+4 (STATUS);
  - `priv` changes visibly at T+5;
  - `redirect_valid`/`flush_all` pulse in T+5 with `trap_stall`=0;
  - IDLE again at T+6.
- `xret` accepted at T:
  - STATUS write in T+1, `priv` updated at T+2;
  - redirect in T+2, IDLE at T+3.
- `csr_*` outputs are combinational from the state and latched data; `csr_we`=0 outside W_* states.
- Reset asserted in any state: the next cycle is IDLE with reset values; no redirect and no partial-write completion.
- A WB exception arriving in the REDIRECT cycle is ignored, since it is being flushed.

## Configuration
- `TRAP_VECTORED_EN`:
  - Defined: when tvec[1:0]==1 and `ecause[63]`=1, `redirect_pc` = (tvec & ~3) + 4·`ecause[5:0]`.
  - Undefined: tvec[1:0] is ignored and every trap uses direct mode, (tvec & ~3).

## Structure
- Package `TrapPkg` holds:
  - the state enum;
  - CSR address constants (MSTATUS, MEPC, MCAUSE, MTVAL, SEPC, SCAUSE, STVAL);
  - mstatus bit-position constants;
  - privilege encodings.
- ExceptPack stays in `ExceptStruct`.
- One sub-module, `TrapVecCalc`: combinational tvec-to-redirect-PC computation, including the vectored option.

## Test plan
- Ecall from U, `medeleg`=0, mtvec=0x8000_0100:
  - writes 0x341=epc, 0x342=8, 0x343=0 and 0x300 with MPP=0, MIE=0;
  - `priv`=3 and a redirect to 0x8000_0100, all at T+5.
- Page fault from S with `medeleg[13]`=1, stvec=0x8000_2000:
  - writes go to 0x141/0x142/0x143 and SPP=1;
  - `priv`=1 and redirect to 0x8000_2000.
- `mret` with MPP=0, MPIE=1, mepc=0x1000:
  - mstatus write has MIE=1, MPP=0;
  - `priv`=0 and redirect to 0x1000 at T+2.
- Exception and `mret` asserted together: only the trap sequence runs.
- `rst` pulsed in W_CAUSE: `csr_we`=0 and `priv`=3 next cycle, with no redirect.
- With `TRAP_VECTORED_EN`, interrupt cause 7 and mtvec=0x8000_0001: redirect to 0x8000_001C.
  - Without the macro the same stimulus redirects to 0x8000_0000.
